card7seg: RTL and testbench

CARD7SEG -- requirements
Module: card7seg

---
 rtl/card7seg_pkg.sv | 42 ++++
 rtl/card7seg_if.sv | 13 +
 rtl/card7seg_dec.sv | 38 +++
 rtl/card7seg.sv | 45 ++++
 tb/tb_card7seg.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/card7seg_pkg.sv
// Shared card-code enumeration and seven-segment glyphs (active low, bit 6 = g .. bit 0 = a).
package card7seg_pkg;

  localparam int CODE_W  = 4;
  localparam int SEG_W   = 7;
  localparam int SCORE_W = 4;

  // Codes 14 and 15 are deliberately absent: they are the illegal codes.
  typedef enum logic [CODE_W-1:0] {
    NONE  = 4'd0,
    ACE   = 4'd1,
    TWO   = 4'd2,
    THREE = 4'd3,
    FOUR  = 4'd4,
    FIVE  = 4'd5,
    SIX   = 4'd6,
    SEVEN = 4'd7,
    EIGHT = 4'd8,
    NINE  = 4'd9,
    TEN   = 4'd10,
    JACK  = 4'd11,
    QUEEN = 4'd12,
    KING  = 4'd13
  } card_e;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_J     = 7'b1100001;
  localparam logic [SEG_W-1:0] SEG_Q     = 7'b0011000;
  localparam logic [SEG_W-1:0] SEG_K     = 7'b0001001;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;

endpackage

// File: rtl/card7seg_if.sv
// Card code in, decoded glyph/score/error out; the decoder sits on the slave side.
interface card7seg_if;
  import card7seg_pkg::*;

  logic [CODE_W-1:0]  code;
  logic [SEG_W-1:0]   seg;
  logic [SCORE_W-1:0] score;
  logic               err;

  modport master (output code, input seg, input score, input err);
  modport slave  (input code, output seg, output score, output err);

endinterface

// File: rtl/card7seg_dec.sv
// Purely combinational card-code decoder: code -> {glyph, baccarat score, illegal flag}.
module card7seg_dec
  import card7seg_pkg::*;
(
  card7seg_if.slave dec
);

  always_comb begin
    dec.seg   = SEG_F;
    dec.score = '0;
    dec.err   = 1'b0;
    case (dec.code)
      NONE:  dec.seg = SEG_BLANK;
      ACE:   dec.seg = SEG_A;
      TWO:   dec.seg = SEG_2;
      THREE: dec.seg = SEG_3;
      FOUR:  dec.seg = SEG_4;
      FIVE:  dec.seg = SEG_5;
      SIX:   dec.seg = SEG_6;
      SEVEN: dec.seg = SEG_7;
      EIGHT: dec.seg = SEG_8;
      NINE:  dec.seg = SEG_9;
      TEN:   dec.seg = SEG_0;
      JACK:  dec.seg = SEG_J;
      QUEEN: dec.seg = SEG_Q;
      KING:  dec.seg = SEG_K;
      default: begin
        dec.seg = SEG_F;
        dec.err = 1'b1;
      end
    endcase
    // Only pip cards carry their face value; ten and courts count zero.
    if (dec.code >= 4'd1 && dec.code <= 4'd9) begin
      dec.score = dec.code;
    end
  end

endmodule

// File: rtl/card7seg.sv
// Card display: decoder followed by one output register bank (one-cycle latency, async reset to blank).
module card7seg
  import card7seg_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [CODE_W-1:0]  SW,
  output logic [SEG_W-1:0]   HEX0,
  output logic [SCORE_W-1:0] card_score,
  output logic               card_err
);

  card7seg_if dec_if ();

  logic [SEG_W-1:0]   hex_d,   hex_q;
  logic [SCORE_W-1:0] score_d, score_q;
  logic               err_d,   err_q;

  assign dec_if.code = SW;

  card7seg_dec u_dec (
    .dec (dec_if.slave)
  );

  assign hex_d   = dec_if.seg;
  assign score_d = dec_if.score;
  assign err_d   = dec_if.err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_q   <= SEG_BLANK;
      score_q <= '0;
      err_q   <= 1'b0;
    end else begin
      hex_q   <= hex_d;
      score_q <= score_d;
      err_q   <= err_d;
    end
  end

  assign HEX0       = hex_q;
  assign card_score = score_q;
  assign card_err   = err_q;

endmodule

// File: tb/tb_card7seg.sv
// Directed bench for card7seg: reset, full code sweep, scores, illegal codes, latency, mid-run reset.
module tb_card7seg;

  logic clk;
  logic clk_en;
  logic reset;

  card7seg_if bus ();

  card7seg dut (
    .clk        (clk),
    .reset      (reset),
    .SW         (bus.code),
    .HEX0       (bus.seg),
    .card_score (bus.score),
    .card_err   (bus.err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Hand-written expected decode {seg[6:0], score[3:0], err}.
  function automatic logic [11:0] ref_of(input logic [3:0] c);
    case (c)
      4'd0:  return {7'b1111111, 4'd0, 1'b0};
      4'd1:  return {7'b0001000, 4'd1, 1'b0};
      4'd2:  return {7'b0100100, 4'd2, 1'b0};
      4'd3:  return {7'b0110000, 4'd3, 1'b0};
      4'd4:  return {7'b0011001, 4'd4, 1'b0};
      4'd5:  return {7'b0010010, 4'd5, 1'b0};
      4'd6:  return {7'b0000010, 4'd6, 1'b0};
      4'd7:  return {7'b1111000, 4'd7, 1'b0};
      4'd8:  return {7'b0000000, 4'd8, 1'b0};
      4'd9:  return {7'b0010000, 4'd9, 1'b0};
      4'd10: return {7'b1000000, 4'd0, 1'b0};
      4'd11: return {7'b1100001, 4'd0, 1'b0};
      4'd12: return {7'b0011000, 4'd0, 1'b0};
      4'd13: return {7'b0001001, 4'd0, 1'b0};
      default: return {7'b0001110, 4'd0, 1'b1};
    endcase
  endfunction

  task automatic chk_outs(input string tag, input logic [11:0] e);
    chk({tag, ".hex"},   {9'd0, bus.seg},    {9'd0, e[11:5]});
    chk({tag, ".score"}, {12'd0, bus.score}, {12'd0, e[4:1]});
    chk({tag, ".err"},   {15'd0, bus.err},   {15'd0, e[0]});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [3:0] c);
    @(negedge clk);
    bus.code = c;
    exp_q.push_back(ref_of(c));
  endtask

  task automatic step(input logic [3:0] c);
    logic [11:0] e;
    drive(c);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 16'd1, 16'd0);
    end else begin
      e = exp_q.pop_front();
      chk_outs($sformatf("sw%0d", c), e);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clk_en   = 1'b0;
    reset    = 1'b0;
    bus.code = 4'd5;

    // Reset with no clock running must blank the outputs at once.
    #3 reset = 1'b1;
    #1 chk_outs("rst_noclk", {7'b1111111, 4'd0, 1'b0});

    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_outs("rst_held", {7'b1111111, 4'd0, 1'b0});
    @(negedge clk);
    reset = 1'b0;

    for (int c = 0; c < 16; c++) step(c[3:0]);
    step(4'd0);  // wrap 15 -> 0 back to blank

    step(4'd9);
    step(4'd10);
    step(4'd12);
    step(4'd13);
    step(4'd1);

    step(4'd14);
    step(4'd15);
    step(4'd13);

    // Latency: change SW between edges, outputs must hold until the next edge.
    step(4'd3);
    #2 bus.code = 4'd9;
    #1 chk_outs("latency_hold", {7'b0110000, 4'd3, 1'b0});
    @(posedge clk);
    #1 chk_outs("latency_upd", {7'b0010000, 4'd9, 1'b0});

    // Reset mid-sweep with SW=8.
    step(4'd6);
    @(negedge clk);
    bus.code = 4'd8;
    #1 reset = 1'b1;
    #1 chk_outs("rst_mid", {7'b1111111, 4'd0, 1'b0});
    @(posedge clk);
    #1 chk_outs("rst_mid_edge", {7'b1111111, 4'd0, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 chk_outs("rst_release", {7'b0000000, 4'd8, 1'b0});

    step(4'd7);
    step(4'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
